// File: rtl/pdm_dec_pkg_341431502448362067.sv
// Shared definitions for the PDM boxcar decimator.
//
// Purpose : default geometry of the decimator and the scaling/saturation
//           helpers used to turn a window's ones-count into a PCM sample.
// Contents:
//   DEC_LOG2_DEF, OUT_W_DEF : default window log2 and sample width
//   WIN_LEN, ACC_W, SAT_MAX : derived geometry for the default build
//   scale_raw()             : shift a ones-count to the output scale, unclipped
//   scale_sat()             : scale_raw() clamped to the output full scale
package pdm_dec_pkg_341431502448362067;

  localparam int DEC_LOG2_DEF = 5;
  localparam int OUT_W_DEF    = 5;

  localparam int WIN_LEN = 2 ** DEC_LOG2_DEF;
  localparam int ACC_W   = DEC_LOG2_DEF + 1;
  localparam int SAT_MAX = 2 ** OUT_W_DEF - 1;

  // A full window of ones produces 2^dec_log2, which after scaling lands
  // exactly one code above full scale; every other count fits.
  function automatic logic [31:0] scale_raw(input logic [31:0] total,
                                            input int          dec_log2,
                                            input int          out_w);
    logic [31:0] res;
    if (dec_log2 >= out_w) begin
      res = total >> (dec_log2 - out_w);
    end else begin
      res = total << (out_w - dec_log2);
    end
    return res;
  endfunction

  function automatic logic [31:0] scale_sat(input logic [31:0] total,
                                            input int          dec_log2,
                                            input int          out_w);
    logic [31:0] raw;
    logic [31:0] sat;
    raw = scale_raw(total, dec_log2, out_w);
    sat = (32'd1 << out_w) - 32'd1;
    return (raw > sat) ? sat : raw;
  endfunction

endpackage

// File: rtl/pdm_dec_outbuf_341431502448362067.sv
// One-entry valid/ready output buffer for decimated samples.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   load         : a new sample is available this cycle
//   data         : the new sample
//   ready        : consumer accepts sample_out while sample_valid is high
//   sample_out   : buffered sample; holds its last value after consumption
//   sample_valid : buffer holds an unconsumed sample
//   overrun      : sticky; an unconsumed sample was overwritten
module pdm_dec_outbuf_341431502448362067 #(
  parameter int OUT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [OUT_W-1:0] data,
  input  logic             ready,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  output logic             overrun
);

  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) begin
      // A load always wins; it only counts as an overrun when the old
      // sample is still pending and is not being taken this same cycle.
      data_d  = data;
      valid_d = 1'b1;
      if (valid_q && !ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_out   = data_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: rtl/pdm_decimator_341431502448362067.sv
// First-order boxcar decimator for a 1-bit PDM stream.
//
// Counts ones over windows of 2^DEC_LOG2 enabled cycles and emits one scaled,
// saturated PCM sample per window into a one-entry valid/ready buffer.
//
// Optional feature: define PDM_DEC_CLIP_FLAG_EN to add the sticky 'clip'
// output, set on the edge that loads a saturated sample.
//
// Ports:
//   clk          : clock
//   reset        : synchronous active-high reset, clears all state
//   enable       : 1 = consume pdm_in this cycle, 0 = freeze window state
//   pdm_in       : PDM bitstream (same clock domain)
//   sample_ready : consumer handshake
//   sample_out   : decimated sample (OUT_W bits)
//   sample_valid : an unconsumed sample is buffered
//   overrun      : sticky, an unconsumed sample was overwritten
//   clip         : (PDM_DEC_CLIP_FLAG_EN only) sticky, a sample saturated
module pdm_decimator_341431502448362067
  import pdm_dec_pkg_341431502448362067::*;
#(
  parameter int DEC_LOG2 = DEC_LOG2_DEF,
  parameter int OUT_W    = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pdm_in,
  input  logic             sample_ready,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
`ifdef PDM_DEC_CLIP_FLAG_EN
  output logic             clip,
`endif
  output logic             overrun
);

  localparam int ACC_W_L   = DEC_LOG2 + 1;
  localparam int SAT_MAX_L = 2 ** OUT_W - 1;

  localparam logic [DEC_LOG2-1:0] CNT_LAST = '1;

  logic [DEC_LOG2-1:0] cnt_q, cnt_d;
  logic [ACC_W_L-1:0]  acc_q, acc_d;
  logic [ACC_W_L-1:0]  total;
  logic                win_end;
  logic [OUT_W-1:0]    scaled;

  // Count of ones including the bit arriving this cycle; at window end this
  // is the window total (0..2^DEC_LOG2, which needs the extra accumulator bit).
  assign total   = acc_q + ACC_W_L'(pdm_in);
  assign win_end = enable && (cnt_q == CNT_LAST);
  assign scaled  = OUT_W'(scale_sat(32'(total), DEC_LOG2, OUT_W));

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (enable) begin
      if (win_end) begin
        // Next window starts on the very next enabled cycle.
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + DEC_LOG2'(1);
        acc_d = total;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

`ifdef PDM_DEC_CLIP_FLAG_EN
  logic clip_q, clip_d;

  always_comb begin
    clip_d = clip_q;
    if (win_end && (scale_raw(32'(total), DEC_LOG2, OUT_W) > 32'(SAT_MAX_L))) begin
      clip_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clip_q <= 1'b0;
    end else begin
      clip_q <= clip_d;
    end
  end

  assign clip = clip_q;
`endif

  pdm_dec_outbuf_341431502448362067 #(
    .OUT_W (OUT_W)
  ) u_outbuf (
    .clk          (clk),
    .reset        (reset),
    .load         (win_end),
    .data         (scaled),
    .ready        (sample_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

endmodule

// File: tb/tb_pdm_decimator_341431502448362067.sv
// Directed bench for the PDM decimator (default DEC_LOG2=5, OUT_W=5).
module tb_pdm_decimator_341431502448362067;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       pdm_in;
  logic       sample_ready;
  logic [4:0] sample_out;
  logic       sample_valid;
  logic       overrun;
`ifdef PDM_DEC_CLIP_FLAG_EN
  logic       clip;
`endif

  int checks = 0;
  int errors = 0;
  int mod_acc = 0;

  pdm_decimator_341431502448362067 dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pdm_in       (pdm_in),
    .sample_ready (sample_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
`ifdef PDM_DEC_CLIP_FLAG_EN
    .clip         (clip),
`endif
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pat;        // stimulus pattern, see pat_bit / modulator model
    bit rdy_first;  // sample_ready on cycle 0 of the window
    bit rdy_mid;    // sample_ready on cycles 1..30
    bit rdy_last;   // sample_ready on cycle 31 (the window-end edge)
    int exp_out;
    bit exp_valid;
    bit exp_ovr;
  } vec_t;

  vec_t tbl[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // 0: zeros, 1: ones, 2: alternating (16 ones), 3: every 4th (8 ones),
  // 4: first 20 ones, 5: first 10 ones.
  function automatic bit pat_bit(input int pat, input int i);
    case (pat)
      1:       return 1'b1;
      2:       return (i % 2) == 0;
      3:       return (i % 4) == 0;
      4:       return i < 20;
      5:       return i < 10;
      default: return 1'b0;
    endcase
  endfunction

  // First-order modulator with 5-bit input 10: 10 ones per 32 cycles.
  function automatic bit mod_bit();
    mod_acc += 10;
    if (mod_acc >= 32) begin
      mod_acc -= 32;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; pdm_in = 1'b0; sample_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mod_acc = 0;
  endtask

  initial begin
    int pulses;
    int first_k;
    int last_k;
    bit exp_clip;

    tbl[0] = '{1, 1, 1, 1, 31, 1, 0};
    tbl[1] = '{0, 1, 1, 1,  0, 1, 0};
    tbl[2] = '{2, 1, 1, 1, 16, 1, 0};
    tbl[3] = '{6, 1, 1, 1, 10, 1, 0};
    tbl[4] = '{6, 1, 1, 1, 10, 1, 0};
    tbl[5] = '{5, 0, 0, 1, 10, 1, 0};  // load and consume on the same edge
    tbl[6] = '{2, 1, 0, 0, 16, 1, 0};
    tbl[7] = '{3, 0, 0, 0,  8, 1, 1};  // overwrite unconsumed 16
    tbl[8] = '{4, 1, 1, 1, 20, 1, 1};  // overrun is sticky

    // Reset state
    do_reset();
    chk("reset_out", sample_out, 0);
    chk("reset_valid", sample_valid, 0);
    chk("reset_ovr", overrun, 0);
`ifdef PDM_DEC_CLIP_FLAG_EN
    chk("reset_clip", clip, 0);
`endif

    // Latency: all ones, valid only after the 32nd enabled cycle
    enable = 1'b1; pdm_in = 1'b1; sample_ready = 1'b1;
    for (int i = 0; i < 31; i++) begin
      tick();
      chk("latency_early_valid", sample_valid, 0);
    end
    tick();
    chk("latency_valid", sample_valid, 1);
    chk("latency_out_sat", sample_out, 31);
`ifdef PDM_DEC_CLIP_FLAG_EN
    chk("latency_clip", clip, 1);
`endif
    tick();
    chk("consume_valid", sample_valid, 0);
    chk("consume_out_hold", sample_out, 31);
    $display("seq latency: out=%0d", sample_out);

    // Back-to-back alternating windows: pulses 32 cycles apart, one cycle wide
    do_reset();
    enable = 1'b1; sample_ready = 1'b1;
    pulses = 0; first_k = 0; last_k = 0;
    for (int k = 1; k <= 96; k++) begin
      pdm_in = pat_bit(2, (k - 1) % 32);
      tick();
      if (sample_valid) begin
        if (pulses == 0) first_k = k;
        else chk("pulse_spacing", k - last_k, 32);
        chk("pulse_out", sample_out, 16);
        last_k = k;
        pulses++;
      end
    end
    chk("pulse_count", pulses, 3);
    chk("pulse_first", first_k, 32);
    $display("seq back-to-back: pulses=%0d first=%0d", pulses, first_k);

    // Enable low for 7 cycles mid-window
    do_reset();
    enable = 1'b1; pdm_in = 1'b1; sample_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    enable = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("pause_no_early", sample_valid, 0);
    tick();
    chk("pause_valid", sample_valid, 1);
    chk("pause_out", sample_out, 31);
    $display("seq pause: out=%0d", sample_out);

    // Reset at cnt=20 discards the partial window
    do_reset();
    enable = 1'b1; pdm_in = 1'b1; sample_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_valid", sample_valid, 0);
    chk("midrst_out", sample_out, 0);
    for (int i = 0; i < 31; i++) begin
      pdm_in = pat_bit(2, i);
      tick();
    end
    chk("midrst_no_early", sample_valid, 0);
    pdm_in = pat_bit(2, 31);
    tick();
    chk("midrst_valid_after", sample_valid, 1);
    chk("midrst_out_after", sample_out, 16);
    $display("seq mid-window reset: out=%0d", sample_out);

    // Table-driven windows, back to back
    do_reset();
    exp_clip = 1'b0;
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 32; i++) begin
        enable = 1'b1;
        pdm_in = (tbl[v].pat == 6) ? mod_bit() : pat_bit(tbl[v].pat, i);
        sample_ready = (i == 0) ? tbl[v].rdy_first :
                       (i == 31) ? tbl[v].rdy_last : tbl[v].rdy_mid;
        tick();
      end
      if (tbl[v].pat == 1) exp_clip = 1'b1;
      chk($sformatf("tbl%0d_out", v), sample_out, tbl[v].exp_out);
      chk($sformatf("tbl%0d_valid", v), sample_valid, tbl[v].exp_valid);
      chk($sformatf("tbl%0d_ovr", v), overrun, tbl[v].exp_ovr);
`ifdef PDM_DEC_CLIP_FLAG_EN
      chk($sformatf("tbl%0d_clip", v), clip, exp_clip);
`endif
      $display("window %0d: pat=%0d out=%0d valid=%0d ovr=%0d",
               v, tbl[v].pat, sample_out, sample_valid, overrun);
    end

    // Consume after the overrun: valid drops, overrun stays, data holds
    enable = 1'b0; sample_ready = 1'b1;
    tick();
    chk("post_valid", sample_valid, 0);
    chk("post_ovr", overrun, 1);
    chk("post_out", sample_out, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_decimator_341431502448362067.md
Name: pdm_decimator_341431502448362067

Overview:
Downstream stage of the 5-bit first-order PDM modulator. Consumes the 1-bit PDM stream and counts ones over fixed windows of 2^DEC_LOG2 enabled cycles, a first-order boxcar/CIC decimator. Each window yields one scaled, saturated PCM sample. The sample sits in a one-entry valid/ready output buffer, so a tile-level loopback or scan logic can check the modulator round-trip.

Parameters:
DEC_LOG2, 5, log2 of window length in cycles; legal range 1..8.
OUT_W, 5, sample_out width; matches the modulator input width.

Ports:
clk  input  1  clock; all state updates on posedge clk
reset  input  1  synchronous, active-high reset
enable  input  1  1 = sample pdm_in this cycle; 0 = freeze window state
pdm_in  input  1  PDM bitstream, same clock domain, no synchroniser
sample_ready  input  1  consumer accepts sample_out when high with sample_valid
sample_out  output  OUT_W  decimated sample
sample_valid  output  1  buffer holds an unconsumed sample
overrun  output  1  sticky; an unconsumed sample was overwritten

Behaviour:
- Reset (sync, active-high) clears all state; takes priority over every other input.
  - Window counter cnt (DEC_LOG2 bits) = 0; ones accumulator acc (DEC_LOG2+1 bits) = 0.
  - sample_out = 0, sample_valid = 0, overrun = 0.
- Window accumulation:
  - Cycle with enable=1 and cnt < 2^DEC_LOG2-1: acc <= acc + pdm_in; cnt <= cnt + 1.
  - enable=0: cnt and acc hold, so pauses extend the window without losing samples.
- Window end: cycle with enable=1 and cnt == 2^DEC_LOG2-1.
  - total = acc + pdm_in, range 0..2^DEC_LOG2.
  - cnt wraps to 0 and acc <= 0 on the same edge; no dead cycle between windows.
- Scaling:
  - DEC_LOG2 >= OUT_W: scaled = total >> (DEC_LOG2-OUT_W).
  - Otherwise: scaled = total << (OUT_W-DEC_LOG2).
  - Saturate to 2^OUT_W-1. Only reachable case is all-ones; with defaults 32 becomes 31.
- Output buffer (one entry). New result loads on the window-end edge: sample_out <= scaled, sample_valid <= 1.
  - Latency: sample_valid first high after the edge that closes the 2^DEC_LOG2-th enabled cycle since reset.
  - Consume: sample_valid & sample_ready with no new result -> sample_valid <= 0; sample_out holds its last value.
  - New result with sample_valid=1 and sample_ready=1 in the same cycle: the new sample loads, sample_valid stays 1, no overrun.
  - New result with sample_valid=1 and sample_ready=0: the new sample overwrites, overrun <= 1.
  - overrun clears only on reset.
- sample_ready is ignored while sample_valid=0. sample_out is stable while sample_valid=1 and not yet consumed.
- Reset mid-window discards the partial window; the next window starts cnt=0 on the first enabled cycle after reset.

Optional Feature:
Macro: PDM_DEC_CLIP_FLAG_EN.
- Defined: adds output port clip (1 bit, reset 0).
  - Sticky-set when a window result saturates; cleared only by reset.
  - Sets on the same edge that loads the clipped sample.
- Undefined: no clip port, no clip logic; saturation still applies.

Decomposition:
- Package pdm_dec_pkg_341431502448362067:
  - localparams WIN_LEN = 2**DEC_LOG2, ACC_W = DEC_LOG2+1, SAT_MAX = 2**OUT_W-1.
  - Function scale_sat(total) implementing the shift plus saturation.
- One natural sub-module: pdm_dec_outbuf_341431502448362067.
  - Inputs load, data, ready; outputs sample_out, sample_valid, overrun.
- Window counter and accumulator stay in the top module.

Test Plan:
- Defaults, enable=1, pdm_in=1 constant, sample_ready=1 -> sample_valid after 32nd enabled cycle, sample_out=31, clip=1 if enabled.
- pdm_in=0 for 32 cycles -> sample_out=0, sample_valid=1 for one cycle only, then 0.
- pdm_in alternating 1,0 -> every window sample_out=16. Back-to-back windows give valid pulses exactly 32 cycles apart.
- Upstream modulator driven with constant input 10 from reset, output into pdm_in -> every window sample_out=10.
- sample_ready=0 across two windows (values 16 then 8) -> after second window sample_out=8, overrun=1. Ready=1 then drops valid; overrun stays 1.
- enable low for 7 cycles mid-window with pdm_in=1 -> window still closes after 32 enabled cycles. Reset at cnt=20 -> no sample; next sample after 32 further enabled cycles.
